// File: rtl/fft_frame_stream_ctrl.sv
// Multi-frame stream source and burst capture unit for the 64-point FFT datapath.
// Plays preloaded source frames with Data_Start framing and captures output bursts into a readback RAM.
module fft_frame_stream_ctrl #(
    parameter int N_POINTS = 64,
    parameter int DATA_W   = 32,
    parameter int N_FRAMES = 4,
    parameter int GAP_CYC  = 0,
    localparam int PW = $clog2(N_POINTS),
    localparam int FW = $clog2(N_FRAMES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [FW:0]       num_frames_i,
    input  logic              load_we_i,
    input  logic [FW+PW-1:0]  load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic [DATA_W-1:0] In_Stream_o,
    output logic              Data_Start_o,
    input  logic [DATA_W-1:0] Out_Stream_i,
    input  logic              Data_Out_i,
    input  logic [FW+PW-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [FW:0]       frames_sent_o,
    output logic [FW:0]       frames_captured_o,
    output logic              overrun_o
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [FW:0]    NF_MAX   = (FW+1)'(N_FRAMES);
    localparam logic [FW:0]    ONE_F    = (FW+1)'(1);
    localparam logic [PW-1:0]  LAST_IDX = PW'(N_POINTS - 1);
    localparam logic [PW-1:0]  ONE_P    = PW'(1);
    localparam logic [GW-1:0]  GAP_LOAD = GW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
    localparam logic [GW-1:0]  ONE_G    = GW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_WAIT
    } src_state_e;

    typedef enum logic {
        C_IDLE,
        C_BURST
    } cap_state_e;

    src_state_e src_state_q, src_state_d;
    cap_state_e cap_state_q, cap_state_d;

    logic [FW-1:0]     frame_q, frame_d;
    logic [PW-1:0]     widx_q, widx_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [FW:0]       nf_q, nf_d;
    logic              done_q, done_d;
    logic              ds_q;
    logic              last_q;
    logic [FW:0]       frames_sent_q;
    logic              issue;
    logic              run_start;
    logic [FW:0]       nf_clamped;
    logic              last_frame;

    logic [PW-1:0]     cidx_q, cidx_d;
    logic              drop_q, drop_d;
    logic [FW:0]       frames_captured_q;
    logic              overrun_q;
    logic              cap_we;
    logic              cap_done;
    logic              ovr_set;
    logic [PW-1:0]     cap_idx;
    logic [FW+PW-1:0]  cap_waddr;

    logic [DATA_W-1:0] src_ram [N_FRAMES*N_POINTS];
    logic [DATA_W-1:0] cap_ram [N_FRAMES*N_POINTS];
    logic [DATA_W-1:0] src_rd_q;
    logic [DATA_W-1:0] cap_rd_q;
    logic              rd_vld_q;

    assign nf_clamped = (num_frames_i > NF_MAX) ? NF_MAX : num_frames_i;
    assign last_frame = (({1'b0, frame_q} + ONE_F) == nf_q);

    // Source sequencing; start is refused on the done cycle so a run cannot chain onto its own completion.
    always_comb begin
        src_state_d = src_state_q;
        frame_d     = frame_q;
        widx_d      = widx_q;
        gap_d       = gap_q;
        nf_d        = nf_q;
        done_d      = 1'b0;
        issue       = 1'b0;
        run_start   = 1'b0;
        case (src_state_q)
            S_IDLE: begin
                if (start_i && !done_q) begin
                    if (num_frames_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        nf_d        = nf_clamped;
                        frame_d     = '0;
                        widx_d      = '0;
                        run_start   = 1'b1;
                        src_state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                issue  = 1'b1;
                widx_d = widx_q + ONE_P;
                if (widx_q == LAST_IDX) begin
                    if (last_frame) begin
                        src_state_d = S_WAIT;
                    end else begin
                        frame_d = frame_q + FW'(1);
                        if (GAP_CYC > 0) begin
                            gap_d       = GAP_LOAD;
                            src_state_d = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    src_state_d = S_SEND;
                end else begin
                    gap_d = gap_q - ONE_G;
                end
            end
            S_WAIT: begin
                if (frames_captured_q == nf_q) begin
                    done_d      = 1'b1;
                    src_state_d = S_IDLE;
                end
            end
            default: src_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src_state_q   <= S_IDLE;
            frame_q       <= '0;
            widx_q        <= '0;
            gap_q         <= '0;
            nf_q          <= '0;
            done_q        <= 1'b0;
            ds_q          <= 1'b0;
            last_q        <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            src_state_q <= src_state_d;
            frame_q     <= frame_d;
            widx_q      <= widx_d;
            gap_q       <= gap_d;
            nf_q        <= nf_d;
            done_q      <= done_d;
            ds_q        <= issue;
            last_q      <= issue && (widx_q == LAST_IDX);
            if (run_start) begin
                frames_sent_q <= '0;
            end else if (last_q && (frames_sent_q != NF_MAX)) begin
                frames_sent_q <= frames_sent_q + ONE_F;
            end
        end
    end

    // Source RAM: address is issued one cycle ahead of Data_Start so the read latency is hidden.
    always_ff @(posedge clk_i) begin
        if (load_we_i && (src_state_q == S_IDLE)) begin
            src_ram[load_addr_i] <= load_data_i;
        end
        src_rd_q <= src_ram[{frame_q, widx_q}];
    end

    always_comb begin
        cap_state_d = cap_state_q;
        cidx_d      = cidx_q;
        drop_d      = drop_q;
        cap_we      = 1'b0;
        cap_done    = 1'b0;
        ovr_set     = 1'b0;
        case (cap_state_q)
            C_IDLE: begin
                if (Data_Out_i) begin
                    ovr_set     = (frames_captured_q == NF_MAX);
                    drop_d      = (frames_captured_q == NF_MAX);
                    cap_we      = (frames_captured_q != NF_MAX);
                    cidx_d      = ONE_P;
                    cap_state_d = C_BURST;
                end
            end
            C_BURST: begin
                cap_we = !drop_q;
                cidx_d = cidx_q + ONE_P;
                if (cidx_q == LAST_IDX) begin
                    cap_done    = !drop_q;
                    cap_state_d = C_IDLE;
                end
            end
            default: cap_state_d = C_IDLE;
        endcase
    end

    assign cap_idx   = (cap_state_q == C_IDLE) ? '0 : cidx_q;
    assign cap_waddr = {frames_captured_q[FW-1:0], cap_idx};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_state_q       <= C_IDLE;
            cidx_q            <= '0;
            drop_q            <= 1'b0;
            frames_captured_q <= '0;
            overrun_q         <= 1'b0;
            rd_vld_q          <= 1'b0;
        end else begin
            cap_state_q <= cap_state_d;
            cidx_q      <= cidx_d;
            drop_q      <= drop_d;
            rd_vld_q    <= 1'b1;
            if (run_start) begin
                frames_captured_q <= '0;
            end else if (cap_done && (frames_captured_q != NF_MAX)) begin
                frames_captured_q <= frames_captured_q + ONE_F;
            end
            if (run_start) begin
                overrun_q <= 1'b0;
            end else if (ovr_set) begin
                overrun_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cap_we) begin
            cap_ram[cap_waddr] <= Out_Stream_i;
        end
        cap_rd_q <= cap_ram[rd_addr_i];
    end

    assign In_Stream_o       = ds_q ? src_rd_q : '0;
    assign Data_Start_o      = ds_q;
    assign rd_data_o         = rd_vld_q ? cap_rd_q : '0;
    assign busy_o            = (src_state_q != S_IDLE);
    assign done_o            = done_q;
    assign frames_sent_o     = frames_sent_q;
    assign frames_captured_o = frames_captured_q;
    assign overrun_o         = overrun_q;

endmodule

// File: tb/tb_fft_frame_stream_ctrl.sv
// Scoreboard bench for fft_frame_stream_ctrl: one instance back-to-back (GAP_CYC=0), one with GAP_CYC=3.
// Expected stream/readback words are queued at stimulus time and popped by a negedge monitor.
module tb_fft_frame_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start0, start3, load_we;
    logic        inj_en0, inj_en3, inj_do;
    logic [2:0]  num_frames;
    logic [7:0]  load_addr, rd_addr;
    logic [31:0] load_data, inj_data;

    logic [31:0] is0, rd0, os0, is3, rd3, os3;
    logic        ds0, busy0, done0, ovr0, do0;
    logic        ds3, busy3, done3, ovr3, do3;
    logic [2:0]  fs0, fc0, fs3, fc3;

    assign do0 = inj_en0 ? inj_do : ds0;
    assign os0 = inj_en0 ? inj_data : is0;
    assign do3 = inj_en3 ? inj_do : ds3;
    assign os3 = inj_en3 ? inj_data : is3;

    fft_frame_stream_ctrl #(.GAP_CYC(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .num_frames_i(num_frames),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
        .In_Stream_o(is0), .Data_Start_o(ds0), .Out_Stream_i(os0), .Data_Out_i(do0),
        .rd_addr_i(rd_addr), .rd_data_o(rd0), .busy_o(busy0), .done_o(done0),
        .frames_sent_o(fs0), .frames_captured_o(fc0), .overrun_o(ovr0));

    fft_frame_stream_ctrl #(.GAP_CYC(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .start_i(start3), .num_frames_i(num_frames),
        .load_we_i(load_we), .load_addr_i(load_addr), .load_data_i(load_data),
        .In_Stream_o(is3), .Data_Start_o(ds3), .Out_Stream_i(os3), .Data_Out_i(do3),
        .rd_addr_i(rd_addr), .rd_data_o(rd3), .busy_o(busy3), .done_o(done3),
        .frames_sent_o(fs3), .frames_captured_o(fc3), .overrun_o(ovr3));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] q0[$], q3[$], rq0[$], rq3[$];
    int bursts0[$], bursts3[$], gaps3[$];
    int run0 = 0, run3 = 0, idle3 = 0, first_ds0 = -1;
    int done_cnt0 = 0, done_cnt3 = 0;
    bit seen3 = 1'b0, ds3_prev = 1'b0;
    bit rp0 = 1'b0, rp3 = 1'b0, rreq0 = 1'b0, rreq3 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] src_val(input int a);
        return (a < 64) ? 32'(a) : (32'hC0DE_0000 | 32'(a));
    endfunction

    always @(negedge clk) begin
        if (ds0) begin
            if (q0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL stream0_extra: got %0h with nothing expected", is0);
            end else begin
                chk("stream0", is0, q0.pop_front());
            end
            if (first_ds0 < 0) first_ds0 = cyc;
            run0++;
        end else if (run0 > 0) begin
            bursts0.push_back(run0);
            run0 = 0;
        end
        if (ds3) begin
            if (q3.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL stream3_extra: got %0h with nothing expected", is3);
            end else begin
                chk("stream3", is3, q3.pop_front());
            end
            if (!ds3_prev && seen3) gaps3.push_back(idle3);
            seen3 = 1'b1;
            idle3 = 0;
            run3++;
        end else begin
            if (run3 > 0) begin
                bursts3.push_back(run3);
                run3 = 0;
            end
            idle3++;
        end
        ds3_prev = ds3;
        if (done0) done_cnt0++;
        if (done3) done_cnt3++;
        if (rp0) chk("rd0", rd0, rq0.pop_front());
        if (rp3) chk("rd3", rd3, rq3.pop_front());
        rp0 = rreq0;
        rp3 = rreq3;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input bit which, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = which ? done3 : done0;
        end
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL done%0d_timeout: got no done, expected done within %0d cycles", which ? 3 : 0, budget);
        end
        step();
    endtask

    task automatic run(input bit which, input logic [2:0] nf, input int nwords, input int budget);
        num_frames = nf;
        for (int k = 0; k < nwords; k++) begin
            if (which) q3.push_back(src_val(k)); else q0.push_back(src_val(k));
        end
        if (which) start3 = 1'b1; else start0 = 1'b1;
        step();
        start0 = 1'b0;
        start3 = 1'b0;
        wait_done(which, budget);
    endtask

    task automatic rb(input bit which, input int addr, input logic [31:0] exp);
        rd_addr = addr[7:0];
        if (which) begin rq3.push_back(exp); rreq3 = 1'b1; end
        else begin rq0.push_back(exp); rreq0 = 1'b1; end
        step();
    endtask

    task automatic rb_end();
        rreq0 = 1'b0;
        rreq3 = 1'b0;
        step();
        step();
    endtask

    task automatic inject(input bit which, input logic [31:0] base);
        if (which) inj_en3 = 1'b1; else inj_en0 = 1'b1;
        for (int k = 0; k < 64; k++) begin
            inj_do   = (k == 0);
            inj_data = base + 32'(k);
            step();
        end
        inj_en0 = 1'b0;
        inj_en3 = 1'b0;
        inj_do  = 1'b0;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, base;
        rst = 1'b1; start0 = 1'b1; start3 = 1'b1; num_frames = 3'd1;
        load_we = 1'b0; load_addr = '0; load_data = '0; rd_addr = '0;
        inj_en0 = 1'b0; inj_en3 = 1'b0; inj_do = 1'b0; inj_data = '0;
        step(); step();
        @(negedge clk);
        chk("rst_ds0", ds0, 0);   chk("rst_is0", is0, 0);   chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0); chk("rst_fs0", fs0, 0); chk("rst_fc0", fc0, 0);
        chk("rst_ovr0", ovr0, 0); chk("rst_rd0", rd0, 0);   chk("rst_ds3", ds3, 0);
        chk("rst_busy3", busy3, 0);
        step();
        rst = 1'b0; start0 = 1'b0; start3 = 1'b0;
        step(); step();
        chk("post_rst_ds0", ds0, 0);

        for (int a = 0; a < 256; a++) begin
            load_we = 1'b1; load_addr = a[7:0]; load_data = src_val(a);
            step();
        end
        load_we = 1'b0;
        step();

        // single frame, loopback
        first_ds0 = -1;
        bursts0.delete();
        num_frames = 3'd1;
        for (int k = 0; k < 64; k++) q0.push_back(src_val(k));
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        st = cyc;
        @(negedge clk);
        chk("t1_busy0", busy0, 1);
        chk("t1_ds0", ds0, 0);
        wait_done(1'b0, 400);
        chk("first_ds_cycle", first_ds0, st + 1);
        chk("single_fs", fs0, 1);
        chk("single_fc", fc0, 1);
        chk("single_ovr", ovr0, 0);
        chk("single_busy", busy0, 0);
        chk("single_burst", (bursts0.size() > 0) ? bursts0[0] : -1, 64);
        step(); step(); step();
        chk("single_done_cnt", done_cnt0, 1);
        for (int k = 0; k < 64; k++) rb(1'b0, k, src_val(k));
        rb_end();

        // four frames with 3-cycle gaps
        bursts3.delete(); gaps3.delete(); seen3 = 1'b0;
        run(1'b1, 3'd4, 256, 800);
        chk("gap_fs", fs3, 4);
        chk("gap_fc", fc3, 4);
        chk("gap_ovr", ovr3, 0);
        chk("gap_count", gaps3.size(), 3);
        for (int i = 0; i < gaps3.size(); i++) chk("gap_len", gaps3[i], 3);
        chk("gap_bursts", bursts3.size(), 4);
        for (int i = 0; i < bursts3.size(); i++) chk("gap_burst_len", bursts3[i], 64);
        for (int a = 0; a < 256; a++) rb(1'b1, a, src_val(a));
        rb_end();

        // fifth burst with all slots full
        inject(1'b1, 32'hBAD0_0000);
        chk("ovr_set", ovr3, 1);
        chk("ovr_fc", fc3, 4);
        for (int a = 0; a < 256; a++) rb(1'b1, a, src_val(a));
        rb_end();
        repeat (10) step();
        chk("ovr_sticky", ovr3, 1);
        num_frames = 3'd1;
        for (int k = 0; k < 64; k++) q3.push_back(src_val(k));
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        @(negedge clk);
        chk("ovr_clr_on_start", ovr3, 0);
        wait_done(1'b1, 400);
        chk("ovr_rerun_fc", fc3, 1);
        chk("ovr_rerun_ovr", ovr3, 0);

        // back-to-back two frames
        bursts0.delete();
        run(1'b0, 3'd2, 128, 500);
        chk("b2b_burst", (bursts0.size() > 0) ? bursts0[0] : -1, 128);
        chk("b2b_fs", fs0, 2);
        chk("b2b_fc", fc0, 2);
        chk("b2b_ovr", ovr0, 0);
        for (int a = 0; a < 128; a++) rb(1'b0, a, src_val(a));
        rb_end();

        // capture while idle lands in the next free slot
        inject(1'b0, 32'h5000_0000);
        chk("idle_cap_fc", fc0, 3);
        chk("idle_cap_busy", busy0, 0);
        chk("idle_cap_ovr", ovr0, 0);
        for (int k = 0; k < 64; k++) rb(1'b0, 128 + k, 32'h5000_0000 + 32'(k));
        rb_end();

        // num_frames above N_FRAMES clamps to 4
        run(1'b0, 3'd7, 256, 800);
        chk("clamp_fs", fs0, 4);
        chk("clamp_fc", fc0, 4);

        // zero frames: immediate done, never busy
        num_frames = 3'd0;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        @(negedge clk);
        chk("zero_done", done0, 1);
        chk("zero_busy", busy0, 0);
        step();
        chk("zero_done_clear", done0, 0);

        // abort at word 30 of frame 1
        base = done_cnt0;
        bursts0.delete();
        num_frames = 3'd2;
        for (int k = 0; k < 95; k++) q0.push_back(src_val(k));
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        repeat (95) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_ds0", ds0, 0);
        chk("abort_busy0", busy0, 0);
        chk("abort_is0", is0, 0);
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("abort_no_done", done_cnt0, base);
        chk("abort_burst", (bursts0.size() > 0) ? bursts0[0] : -1, 95);

        bursts0.delete();
        run(1'b0, 3'd2, 128, 500);
        chk("rerun_fs", fs0, 2);
        chk("rerun_fc", fc0, 2);
        chk("rerun_done_cnt", done_cnt0, base + 1);
        chk("rerun_burst", (bursts0.size() > 0) ? bursts0[0] : -1, 128);

        step(); step();
        chk("q0_drained", q0.size(), 0);
        chk("q3_drained", q3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
